// File: rtl/drv_ctrl_pkg.sv
// Shared types and default widths for the top-switch gate-command generator.
package drv_ctrl_pkg;

    localparam int DT_W_DEF    = 4;
    localparam int MINON_W_DEF = 5;
    localparam int CNT_W_DEF   = 8;

    localparam logic [CNT_W_DEF-1:0] SW_CNT_SAT = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DT_LS,
        ST_BOT_ON,
        ST_DT_HS,
        ST_TOP_ON,
        ST_FAULT_OFF
    } drv_state_t;

endpackage

// File: rtl/dt_down_counter.sv
// Loadable down counter that stops at zero; used for dead time and minimum on-time.
module dt_down_counter #(
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            dec,
    input  logic [DT_W-1:0] load_val,
    output logic            zero
);

    logic [DT_W-1:0] cnt_q;
    logic [DT_W-1:0] cnt_d;

    // Load wins over decrement so a state entry always starts from a fresh value.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - DT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/hs_deadtime_ctrl.sv
// Converts a PWM request into non-overlapping top/bottom gate commands with dead time,
// minimum top on-time, fault latching and a saturating top-switch event counter.
module hs_deadtime_ctrl
    import drv_ctrl_pkg::*;
#(
    parameter int DT_W    = DT_W_DEF,
    parameter int MINON_W = MINON_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               CELV,
    input  logic               CELG,
    input  logic               SUB,
    input  logic               en,
    input  logic               pwm_in,
    input  logic               fault,
    input  logic               fault_clr,
    input  logic [DT_W-1:0]    dt_hs,
    input  logic [DT_W-1:0]    dt_ls,
    input  logic [MINON_W-1:0] min_on,
    output logic               top_on,
    output logic               drv_en,
    output logic               bot_on,
    output logic               fault_flag,
    output logic [CNT_W-1:0]   sw_cnt
);

    localparam logic [CNT_W-1:0] CNT_SAT =
        (CNT_W == CNT_W_DEF) ? CNT_W'(SW_CNT_SAT) : {CNT_W{1'b1}};

    drv_state_t state_q, state_d;

    logic             top_on_q, top_on_d;
    logic             bot_on_q, bot_on_d;
    logic             drv_en_q, drv_en_d;
    logic             fault_flag_q, fault_flag_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;

    logic            dcnt_load, dcnt_dec, dcnt_zero;
    logic [DT_W-1:0] dcnt_val;
    logic            mcnt_load, mcnt_dec, mcnt_zero;

    // Supply and substrate pins exist only for netlist connectivity.
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ SUB;

    dt_down_counter #(.DT_W(DT_W)) u_dcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (dcnt_load),
        .dec      (dcnt_dec),
        .load_val (dcnt_val),
        .zero     (dcnt_zero)
    );

    dt_down_counter #(.DT_W(MINON_W)) u_mcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (mcnt_load),
        .dec      (mcnt_dec),
        .load_val (min_on),
        .zero     (mcnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        sw_cnt_d  = sw_cnt_q;
        dcnt_load = 1'b0;
        dcnt_val  = dt_ls;
        mcnt_load = 1'b0;

        if (fault) begin
            state_d = ST_FAULT_OFF;
        end else if (state_q == ST_FAULT_OFF) begin
            if (fault_clr) begin
                state_d = ST_IDLE;
            end
        end else if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_DT_LS;
                    dcnt_load = 1'b1;
                    dcnt_val  = dt_ls;
                end
                ST_DT_LS: begin
                    if (dcnt_zero) begin
                        state_d = ST_BOT_ON;
                    end
                end
                ST_BOT_ON: begin
                    if (pwm_in) begin
                        state_d   = ST_DT_HS;
                        dcnt_load = 1'b1;
                        dcnt_val  = dt_hs;
                    end
                end
                ST_DT_HS: begin
                    if (dcnt_zero) begin
                        state_d   = ST_TOP_ON;
                        mcnt_load = 1'b1;
                        if (sw_cnt_q != CNT_SAT) begin
                            sw_cnt_d = sw_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_TOP_ON: begin
                    // pwm_in is re-sampled every cycle; an early low request is not held.
                    if (!pwm_in && mcnt_zero) begin
                        state_d   = ST_DT_LS;
                        dcnt_load = 1'b1;
                        dcnt_val  = dt_ls;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        dcnt_dec = (state_q == ST_DT_LS) || (state_q == ST_DT_HS);
        mcnt_dec = (state_q == ST_TOP_ON);

        // Outputs decode the next state so they switch on the same edge as the state.
        top_on_d     = (state_d == ST_TOP_ON);
        bot_on_d     = (state_d == ST_BOT_ON);
        drv_en_d     = (state_d != ST_IDLE) && (state_d != ST_FAULT_OFF);
        fault_flag_d = (state_d == ST_FAULT_OFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            top_on_q     <= 1'b0;
            bot_on_q     <= 1'b0;
            drv_en_q     <= 1'b0;
            fault_flag_q <= 1'b0;
            sw_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            top_on_q     <= top_on_d;
            bot_on_q     <= bot_on_d;
            drv_en_q     <= drv_en_d;
            fault_flag_q <= fault_flag_d;
            sw_cnt_q     <= sw_cnt_d;
        end
    end

    assign top_on     = top_on_q;
    assign bot_on     = bot_on_q;
    assign drv_en     = drv_en_q;
    assign fault_flag = fault_flag_q;
    assign sw_cnt     = sw_cnt_q;

endmodule

// File: tb/tb_hs_deadtime_ctrl.sv
// Directed bench for hs_deadtime_ctrl: dead time, min on-time, faults, saturation, reset.
module tb_hs_deadtime_ctrl;

    logic       clk;
    logic       rst;
    logic       en, pwm_in, fault, fault_clr;
    logic [3:0] dt_hs, dt_ls;
    logic [4:0] min_on;
    logic       top_on, drv_en, bot_on, fault_flag;
    logic [7:0] sw_cnt;

    int n_chk;
    int n_err;

    // Packed view {top_on, bot_on, drv_en, fault_flag}
    localparam logic [3:0] O_OFF   = 4'b0000;
    localparam logic [3:0] O_DEAD  = 4'b0010;
    localparam logic [3:0] O_BOT   = 4'b0110;
    localparam logic [3:0] O_TOP   = 4'b1010;
    localparam logic [3:0] O_FAULT = 4'b0001;

    hs_deadtime_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .CELV       (1'b1),
        .CELG       (1'b0),
        .SUB        (1'b0),
        .en         (en),
        .pwm_in     (pwm_in),
        .fault      (fault),
        .fault_clr  (fault_clr),
        .dt_hs      (dt_hs),
        .dt_ls      (dt_ls),
        .min_on     (min_on),
        .top_on     (top_on),
        .drv_en     (drv_en),
        .bot_on     (bot_on),
        .fault_flag (fault_flag),
        .sw_cnt     (sw_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] outs();
        return {top_on, bot_on, drv_en, fault_flag};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        chk("overlap", {31'd0, top_on & bot_on}, 32'd0);
    end

    logic [3:0] tog_exp [12];

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1; en = 1'b0; pwm_in = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        dt_ls = 4'd3; dt_hs = 4'd2; min_on = 5'd10;
        tog_exp = '{O_BOT, O_BOT, O_DEAD, O_TOP, O_TOP, O_DEAD,
                    O_BOT, O_BOT, O_DEAD, O_TOP, O_TOP, O_DEAD};

        repeat (2) tick();
        chk("reset_outs", outs(), O_OFF);
        chk("reset_cnt", sw_cnt, 0);
        rst = 1'b0;
        tick();
        chk("idle_outs", outs(), O_OFF);

        // Low-side dead time of dt_ls+1 cycles, then bottom on
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dt_ls_first", outs(), O_DEAD);
        end
        tick();
        chk("bot_on_first", outs(), O_BOT);

        // High-side dead time of dt_hs+1 cycles, then top on with first event
        pwm_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dt_hs", outs(), O_DEAD);
            chk("cnt_before_top", sw_cnt, 0);
        end
        tick();
        chk("top_on_entry", outs(), O_TOP);
        chk("cnt_after_top", sw_cnt, 1);

        // Minimum on-time holds top for min_on+1 cycles despite an early low request
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("min_on_hold", outs(), O_TOP);
            if (i == 2) pwm_in = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dt_ls_after_top", outs(), O_DEAD);
        end
        tick();
        chk("bot_on_again", outs(), O_BOT);

        // Fault latching and clearing
        min_on = 5'd0;
        pwm_in = 1'b1;
        repeat (4) tick();
        chk("top_before_fault", outs(), O_TOP);
        chk("cnt_two", sw_cnt, 2);
        fault = 1'b1;
        tick();
        chk("fault_entry", outs(), O_FAULT);
        fault_clr = 1'b1;
        tick();
        chk("clr_ignored", outs(), O_FAULT);
        fault_clr = 1'b0;
        fault = 1'b0;
        tick();
        chk("fault_held", outs(), O_FAULT);
        dt_ls = 4'd0; dt_hs = 4'd0;
        fault_clr = 1'b1;
        tick();
        chk("fault_cleared", outs(), O_OFF);
        chk("cnt_kept", sw_cnt, 2);
        fault_clr = 1'b0;
        tick();
        chk("restart_dt", outs(), O_DEAD);

        // Zero dead time with pwm toggling every cycle
        pwm_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("toggle", outs(), tog_exp[i]);
            pwm_in = ~pwm_in;
        end
        chk("cnt_toggle", sw_cnt, 4);

        // Run enough top events to saturate the counter
        for (int i = 0; i < 1800; i++) begin
            tick();
            pwm_in = ~pwm_in;
        end
        chk("cnt_sat", sw_cnt, 255);
        pwm_in = 1'b1;
        for (int i = 0; i < 20 && !top_on; i++) tick();
        chk("top_wait", top_on, 1);
        repeat (6) tick();
        chk("cnt_sat_hold", sw_cnt, 255);

        // Asynchronous reset in the middle of TOP_ON
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_outs", outs(), O_OFF);
        chk("async_rst_cnt", sw_cnt, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_dt", outs(), O_DEAD);
        en = 1'b0;
        tick();
        chk("en_low_idle", outs(), O_OFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hs_deadtime_ctrl.md
Name: hs_deadtime_ctrl

Overview:
- Sequential gate-command generator directly upstream of the top-driver NAND2 brick in the LOOP/DRIVER/TOPDRIVER path.
- Converts a raw PWM request into non-overlapping top and bottom drive commands.
- Enforces programmable dead time before each edge and a minimum top on-time.
- Drives the NAND's data input (top_on) and enable input (drv_en). Latches faults and forces both switches off.

Parameters:
- DT_W, 4, width of dead-time programming fields, in clock cycles.
- MINON_W, 5, width of the minimum top on-time field.
- CNT_W, 8, width of the saturating top-switch event counter.

Ports:
- clk  input  1  block clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- CELV  input  1  brick supply pin, no RTL function.
- CELG  input  1  brick ground pin, no RTL function.
- SUB  input  1  substrate pin, no RTL function.
- en  input  1  loop enable; low forces IDLE.
- pwm_in  input  1  raw PWM request; 1 = top on, 0 = bottom on.
- fault  input  1  asynchronous-origin fault, already synchronised upstream.
- fault_clr  input  1  single-cycle pulse that clears the latched fault.
- dt_hs  input  DT_W  dead time before top turn-on.
- dt_ls  input  DT_W  dead time before bottom turn-on.
- min_on  input  MINON_W  minimum top on-time, in cycles.
- top_on  output  1  top gate command; feeds NAND2 i0.
- drv_en  output  1  driver enable; feeds NAND2 i1; high in every state except IDLE and FAULT_OFF.
- bot_on  output  1  bottom gate command.
- fault_flag  output  1  latched fault indicator.
- sw_cnt  output  CNT_W  count of TOP_ON entries, saturating.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - top_on, bot_on, drv_en, fault_flag = 0; sw_cnt = 0.
  - All counters = 0.
- Outputs are registered and decoded from the next state. They change on the clock edge where the state changes, with no combinational path from inputs.
- States: IDLE, DT_LS, BOT_ON, DT_HS, TOP_ON, FAULT_OFF.
- Priority, evaluated every cycle: fault, then !en, then normal transition.
  - fault=1 in any state → FAULT_OFF. fault_flag=1, top_on=bot_on=drv_en=0.
  - en=0 in any non-FAULT state → IDLE next cycle, all outputs 0.
- IDLE: en=1 & fault=0 → DT_LS; load dcnt=dt_ls.
- DT_LS / DT_HS:
  - Both gates are 0 and drv_en=1.
  - If dcnt==0, advance; else decrement dcnt.
  - Dead time therefore lasts dt+1 cycles, so dt=0 still gives 1 cycle.
  - dt_* is sampled only at load; changes mid-count are ignored.
  - DT_LS → BOT_ON. DT_HS → TOP_ON, loading mcnt=min_on and incrementing sw_cnt (saturates at all-ones).
- BOT_ON: bot_on=1. pwm_in=1 → DT_HS, loading dcnt=dt_hs.
- TOP_ON:
  - top_on=1. mcnt decrements to 0 and holds there.
  - pwm_in=0 & mcnt==0 → DT_LS, loading dcnt=dt_ls.
  - A pwm_in low seen earlier is not remembered; the exit decision is re-evaluated every cycle.
- FAULT_OFF:
  - Held while fault=1.
  - fault_clr=1 & fault=0 → IDLE with fault_flag cleared.
  - fault_clr while fault=1 is ignored.
- Invariant: top_on & bot_on is never 1 in any cycle, including reset deassertion and fault entry.
- pwm_in toggling during DT_HS/DT_LS does not abort the dead time. The decision is re-evaluated on arrival in BOT_ON/TOP_ON.
- Reset mid-operation → immediate IDLE outputs (async). sw_cnt and fault_flag are cleared.

Decomposition:
- Shared package drv_ctrl_pkg:
  - state enum type drv_state_t;
  - default widths DT_W/MINON_W/CNT_W;
  - localparam for sw_cnt saturation value.
- Sub-module dt_down_counter, DT_W-parametrised, with load/dec/zero. Instantiated twice: dead-time counter and min-on counter (MINON_W).
- FSM and output registers stay in the top module.

Test Plan:
- Reset then en=1, pwm_in=0, dt_ls=3 → 4 cycles with both off and drv_en=1, then bot_on=1; top_on stays 0 throughout.
- From BOT_ON, pwm_in→1 with dt_hs=2 → bot_on drops next edge, 3 both-off cycles, then top_on=1; sw_cnt 0→1.
- min_on=10, pwm_in high for only 2 cycles after TOP_ON entry → top_on stays high exactly 11 cycles, then DT_LS of dt_ls+1 cycles.
- fault=1 during TOP_ON → next edge all gates and drv_en 0, fault_flag=1. fault_clr while fault=1 → no change. Drop fault, pulse fault_clr → IDLE, fault_flag=0.
- dt_hs=0 and dt_ls=0 with pwm_in toggling every cycle and min_on=0 → exactly 1 both-off cycle between every edge; overlap assertion never fires.
- Force 255 top events → sw_cnt saturates at 255 and holds. rst mid-TOP_ON → outputs 0 asynchronously and sw_cnt=0.
